// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch-path constants and the queue entry type.
package fetch_pkg;
  localparam int INST_W = 32;
  localparam int PC_INC = 4;
  typedef struct packed {
    logic [INST_W-1:0] pc;
    logic [INST_W-1:0] ir;
  } entry_t;
endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch packet in, FW-wide head window out; master drives, slave is the queue.
interface fetch_queue_if #(
  parameter int FW = 2,
  parameter int DEPTH = 16,
  parameter int XLEN = fetch_pkg::INST_W
);
  logic flush, in_valid, in_ready;
  logic [FW-1:0] in_mask, out_valid;
  logic [XLEN-1:0] in_pc;
  logic [FW*XLEN-1:0] in_ir, out_ir, out_pc;
  logic [$clog2(FW+1)-1:0] deq_num;
  logic [$clog2(DEPTH+1)-1:0] count;
  modport master (
    output flush, in_valid, in_mask, in_pc, in_ir, deq_num,
    input in_ready, out_valid, out_ir, out_pc, count
  );
  modport slave (
    input flush, in_valid, in_mask, in_pc, in_ir, deq_num,
    output in_ready, out_valid, out_ir, out_pc, count
  );
endinterface

// File: rtl/fq_compact.sv
// fq_compact: packs mask-selected slots to the low end in ascending order, each with its own PC.
module fq_compact #(
  parameter int FW = 2,
  parameter int XLEN = fetch_pkg::INST_W
) (
  input  logic [FW-1:0]              mask,
  input  logic [XLEN-1:0]            pc,
  input  logic [FW*XLEN-1:0]         ir,
  output logic [FW*XLEN-1:0]         pc_o,
  output logic [FW*XLEN-1:0]         ir_o,
  output logic [$clog2(FW+1)-1:0]    n
);
  import fetch_pkg::*;
  localparam int NW = $clog2(FW+1);
  int k;
  always_comb begin
    pc_o = '0;
    ir_o = '0;
    k = 0;
    for (int i = 0; i < FW; i++) begin
      if (mask[i]) begin
        pc_o[k*XLEN +: XLEN] = pc + XLEN'(PC_INC * i);
        ir_o[k*XLEN +: XLEN] = ir[i*XLEN +: XLEN];
        k = k + 1;
      end
    end
    n = NW'(k);
  end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction fetch queue, FW in / up to FW out per cycle.
// FQ_BYPASS_EN: packets arriving while count < FW are shown on outputs the same cycle.
module fetch_queue #(
  parameter int FW = 2,
  parameter int DEPTH = 16,
  parameter int XLEN = fetch_pkg::INST_W
) (
  input logic clk,
  input logic rstn,
  fetch_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int NW = $clog2(FW+1);
  logic [AW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [XLEN-1:0] mem_pc [DEPTH];
  logic [XLEN-1:0] mem_ir [DEPTH];
  logic [FW*XLEN-1:0] c_pc, c_ir;
  logic [NW-1:0] c_n;
  logic enq, byp;
  int enq_n, avail, deq_n, skip;
  fq_compact #(.FW(FW), .XLEN(XLEN)) u_compact (
    .mask(q.in_mask), .pc(q.in_pc), .ir(q.in_ir),
    .pc_o(c_pc), .ir_o(c_ir), .n(c_n)
  );
  assign q.in_ready = (DEPTH - int'(count)) >= FW;
  assign q.count = count;
  assign enq = q.in_valid & q.in_ready & !q.flush;
`ifdef FQ_BYPASS_EN
  assign byp = rstn & enq & (int'(count) < FW);
`else
  assign byp = 1'b0;
`endif
  // skip = bypassed slots consumed this cycle; they never touch storage
  always_comb begin
    enq_n = enq ? int'(c_n) : 0;
    avail = int'(count) + (byp ? enq_n : 0);
    avail = avail < FW ? avail : FW;
    deq_n = int'(q.deq_num) < avail ? int'(q.deq_num) : avail;
    skip = deq_n > int'(count) ? deq_n - int'(count) : 0;
  end
  always_comb begin
    q.out_valid = '0;
    q.out_ir = '0;
    q.out_pc = '0;
    for (int i = 0; i < FW; i++) begin
      if (i < int'(count)) begin
        q.out_valid[i] = 1'b1;
        q.out_pc[i*XLEN +: XLEN] = mem_pc[head + AW'(i)];
        q.out_ir[i*XLEN +: XLEN] = mem_ir[head + AW'(i)];
      end else if (byp && (i - int'(count)) < enq_n) begin
        q.out_valid[i] = 1'b1;
        q.out_pc[i*XLEN +: XLEN] = c_pc[(i - int'(count))*XLEN +: XLEN];
        q.out_ir[i*XLEN +: XLEN] = c_ir[(i - int'(count))*XLEN +: XLEN];
      end
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else if (q.flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      head <= head + AW'(deq_n - skip);
      tail <= tail + AW'(enq_n - skip);
      count <= CW'(int'(count) + enq_n - deq_n);
    end
  end
  always_ff @(posedge clk) begin
    for (int k = 0; k < FW; k++) begin
      if (k >= skip && k < enq_n) begin
        mem_pc[tail + AW'(k - skip)] <= c_pc[k*XLEN +: XLEN];
        mem_ir[tail + AW'(k - skip)] <= c_ir[k*XLEN +: XLEN];
      end
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and reference-queue checks for fetch_queue.
module tb_fetch_queue;
  import fetch_pkg::*;
  localparam int FW = 2;
  localparam int DEPTH = 16;
  localparam int XLEN = 32;
  localparam int NW = $clog2(FW+1);
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  entry_t mq[$];
  fetch_queue_if #(.FW(FW), .DEPTH(DEPTH), .XLEN(XLEN)) q ();
  fetch_queue #(.FW(FW), .DEPTH(DEPTH), .XLEN(XLEN)) dut (.clk(clk), .rstn(rstn), .q(q));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, compare against the reference queue, then advance the model.
  task automatic step(input logic v, input logic [FW-1:0] m, input logic [XLEN-1:0] pc,
                      input logic [FW*XLEN-1:0] ir, input int dq, input logic fl);
    entry_t pkt[$];
    entry_t vis[$];
    logic [FW-1:0] ev;
    logic [FW*XLEN-1:0] eir, epc;
    bit rdy;
    int d;
    q.in_valid = v;
    q.in_mask = m;
    q.in_pc = pc;
    q.in_ir = ir;
    q.deq_num = NW'(dq);
    q.flush = fl;
    for (int i = 0; i < FW; i++)
      if (m[i]) pkt.push_back('{pc: pc + 32'(4 * i), ir: ir[i*XLEN +: XLEN]});
    rdy = (DEPTH - mq.size()) >= FW;
    for (int i = 0; i < mq.size() && i < FW; i++) vis.push_back(mq[i]);
`ifdef FQ_BYPASS_EN
    if (v && !fl && mq.size() < FW)
      foreach (pkt[i]) if (vis.size() < FW) vis.push_back(pkt[i]);
`endif
    ev = '0;
    eir = '0;
    epc = '0;
    foreach (vis[i]) begin
      ev[i] = 1'b1;
      eir[i*XLEN +: XLEN] = vis[i].ir;
      epc[i*XLEN +: XLEN] = vis[i].pc;
    end
    #2;
    check("out_valid", q.out_valid, ev);
    check("out_ir", q.out_ir, eir);
    check("out_pc", q.out_pc, epc);
    check("count", q.count, mq.size());
    check("in_ready", q.in_ready, rdy);
    d = dq < vis.size() ? dq : vis.size();
    if (fl) mq.delete();
    else begin
      if (v && rdy) foreach (pkt[i]) mq.push_back(pkt[i]);
      repeat (d) void'(mq.pop_front());
    end
    @(posedge clk);
    #1;
    q.in_valid = 1'b0;
    q.deq_num = '0;
    q.flush = 1'b0;
    #1;
  endtask

  initial begin
    q.flush = 1'b0;
    q.in_valid = 1'b0;
    q.in_mask = '0;
    q.in_pc = '0;
    q.in_ir = '0;
    q.deq_num = '0;
    #3;
    check("rst_out_valid", q.out_valid, 0);
    check("rst_count", q.count, 0);
    check("rst_in_ready", q.in_ready, 1);
    #9 rstn = 1'b1;
    @(posedge clk);
    #1;
    step(1, 2'b11, 32'h11111110, 64'h11111111_22222222, 0, 0);
    check("pkt1_valid", q.out_valid, 2'b11);
    check("pkt1_ir", q.out_ir, 64'h11111111_22222222);
    check("pkt1_pc", q.out_pc, 64'h11111114_11111110);
    step(0, 0, 0, 0, 2, 0);
    step(1, 2'b10, 32'h33333330, 64'h33333333_44444444, 0, 0);
    check("pkt2_valid", q.out_valid, 2'b01);
    check("pkt2_ir", q.out_ir, 64'h00000000_33333333);
    check("pkt2_pc", q.out_pc, 64'h00000000_33333334);
    step(1, 2'b00, 32'h55555550, 64'h55555555_66666666, 0, 0);
    check("empty_mask_count", q.count, 1);
    step(0, 0, 0, 0, 2, 0);
    for (int k = 0; k < 7; k++)
      step(1, 2'b11, 32'h1000 + 32'(8 * k), {$urandom, $urandom}, 0, 0);
    step(1, 2'b01, 32'h2000, {$urandom, $urandom}, 0, 0);
    check("full_ready", q.in_ready, 0);
    check("full_count", q.count, 15);
    step(1, 2'b11, 32'h3000, {$urandom, $urandom}, 0, 0);
    step(0, 0, 0, 0, 2, 0);
    check("ready_after_deq", q.in_ready, 1);
    check("count_after_deq", q.count, 13);
    for (int k = 0; k < 200; k++)
      step(($urandom % 4) != 0, FW'($urandom), $urandom & 32'hffff_fffc,
           {$urandom, $urandom}, int'($urandom_range(0, FW)), 0);
    repeat (10) step(0, 0, 0, 0, 2, 0);
    check("drained", q.count, 0);
    for (int k = 0; k < 8; k++)
      step(1, 2'b11, 32'h4000 + 32'(8 * k), {$urandom, $urandom}, 0, 0);
    check("filled", q.count, 16);
    step(1, 2'b11, 32'h5000, {$urandom, $urandom}, 2, 1);
    check("flush_count", q.count, 0);
    check("flush_valid", q.out_valid, 0);
    check("flush_ready", q.in_ready, 1);
    for (int k = 0; k < 3; k++)
      step(1, 2'b11, 32'h6000 + 32'(8 * k), {$urandom, $urandom}, 1, 0);
    q.in_valid = 1'b1;
    q.in_mask = 2'b11;
    rstn = 1'b0;
    #1;
    check("rstlow_valid", q.out_valid, 0);
    check("rstlow_count", q.count, 0);
    check("rstlow_ready", q.in_ready, 1);
    @(posedge clk);
    #1;
    check("rstlow_edge_valid", q.out_valid, 0);
    q.in_valid = 1'b0;
    rstn = 1'b1;
    mq.delete();
    #1;
    check("rstrel_valid", q.out_valid, 0);
    @(posedge clk);
    #1;
    step(1, 2'b01, 32'h7000, {$urandom, $urandom}, 0, 0);
    step(0, 0, 0, 0, 1, 0);
`ifdef FQ_BYPASS_EN
    q.in_valid = 1'b1;
    q.in_mask = 2'b11;
    q.in_pc = 32'h8000;
    q.in_ir = 64'haaaa_aaaa_bbbb_bbbb;
    #1;
    check("bypass_valid", q.out_valid, 2'b11);
    check("bypass_ir", q.out_ir, 64'haaaa_aaaa_bbbb_bbbb);
    q.in_valid = 1'b0;
    #1;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL take parameter FW, default 2: instructions per fetch packet and maximum dequeued per cycle, 1..4.
REQ-002 The block SHALL take parameter DEPTH, default 16: queue entries, power of two, at least 2*FW.
REQ-003 The block SHALL take parameter XLEN, default 32: PC and instruction width.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 rstn  in  1  reset, asynchronous, active-low.
REQ-006 flush  in  1  synchronous flush (redirect); discard all entries.
REQ-007 in_valid  in  1  fetch packet present.
REQ-008 in_mask  in  FW  per-slot valid; bit i qualifies slot i.
REQ-009 in_pc  in  XLEN  PC of slot 0; slot i PC = in_pc + 4*i.
REQ-010 in_ir  in  FW*XLEN  instructions; slot i at bits [i*XLEN +: XLEN].
REQ-011 in_ready  out  1  queue accepts a packet this cycle.
REQ-012 out_valid  out  FW  per-slot valid, oldest entry in slot 0, contiguous from bit 0.
REQ-013 out_ir  out  FW*XLEN  head instructions.
REQ-014 out_pc  out  FW*XLEN  head PCs.
REQ-015 deq_num  in  clog2(FW+1)  number of head entries consumed this cycle.
REQ-016 count  out  clog2(DEPTH+1)  current occupancy.

Function
REQ-017 in_ready SHALL be 1 iff registered free space (DEPTH-count) >= FW; same-cycle dequeue is not credited.
REQ-018 Enqueue SHALL occur iff in_valid & in_ready & !flush, writing only mask-set slots, compacted in ascending slot order with their own PCs.
REQ-019 in_valid with in_mask==0 SHALL be accepted and enqueue nothing.
REQ-020 Dequeue SHALL remove min(deq_num, popcount(out_valid)) oldest entries; excess deq_num is ignored.
REQ-021 Simultaneous enqueue and dequeue SHALL update count = count + enq_n - deq_n in one cycle.
REQ-022 Without the bypass feature, an enqueued entry SHALL first appear on outputs the cycle after acceptance.
REQ-023 Head and tail pointers SHALL wrap modulo DEPTH; output slots spanning the wrap SHALL present entries in correct order.
REQ-024 out_ir/out_pc slots with out_valid clear SHALL be driven to 0.
REQ-025 flush SHALL set head = tail = count = 0 next edge, overriding same-cycle enqueue and dequeue; in_ready SHALL be 1 the following cycle.
REQ-026 count SHALL never exceed DEPTH nor underflow; no overflow or underflow state is reachable.

Reset
REQ-027 rstn low SHALL immediately clear head, tail and count, force out_valid=0, out_ir=0, out_pc=0, in_ready=1, including mid-operation; entry storage need not be cleared.

Configuration
REQ-028 With FQ_BYPASS_EN defined, an input packet arriving while count < FW SHALL appear on outputs in the same cycle behind stored entries, and MAY be dequeued that cycle; dequeued bypassed slots are not written.
REQ-029 Without FQ_BYPASS_EN, outputs SHALL depend on registered state only.

Structure
REQ-030 A shared package fetch_pkg SHALL hold INST_W, the PC increment constant 4, and the entry typedef {pc, ir}.
REQ-031 Slot compaction (mask -> packed entries + enq_n) SHALL be a combinational sub-module fq_compact.

Verification
REQ-032 Reset, then in_valid=1, mask=11, in_pc=0x11111110, in_ir=0x11111111_22222222 -> next cycle out_valid=11, out_ir slot0=0x22222222 pc 0x11111110, slot1=0x11111111 pc 0x11111114.
REQ-033 mask=10, in_pc=0x33333330, in_ir=0x33333333_44444444 -> single entry 0x33333333, pc 0x33333334, in slot 0.
REQ-034 Enqueue FW per cycle with deq_num=0 until count=DEPTH-1 (odd masks) -> in_ready=0 at DEPTH-FW+1; deq_num=2 one cycle -> in_ready=1 next cycle.
REQ-035 Fill and drain across 3 pointer wraps, deq_num 0..FW random -> output order and PCs match reference queue model, count exact.
REQ-036 flush asserted with in_valid=1 and deq_num=2 on full queue -> next cycle count=0, out_valid=00, in_ready=1.
REQ-037 rstn pulsed low mid-stream -> out_valid=00 while low and after release; FQ_BYPASS_EN build: empty queue, mask=11 -> out_valid=11 same cycle.
